// File: rtl/ro_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement controller.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } meas_state_t;

  localparam int CNT_W_DEF      = 24;
  localparam int WIN_W_DEF      = 20;
  localparam int SETTLE_CYC_DEF = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// Host-side request/result bundle of the measurement controller.
// Optional RO_MEAS_SAT_EN adds the saturation flag resultOvf.
interface ro_meas_ctrl_if #(
  parameter int CNT_W = 24,
  parameter int WIN_W = 20
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] winLen;
  logic             busy;
  logic             resultValid;
  logic             resultReady;
  logic [CNT_W-1:0] resultCount;
`ifdef RO_MEAS_SAT_EN
  logic             resultOvf;

  modport master (
    output start, abort, winLen, resultReady,
    input  busy, resultValid, resultCount, resultOvf
  );
  modport slave (
    input  start, abort, winLen, resultReady,
    output busy, resultValid, resultCount, resultOvf
  );
`else
  modport master (
    output start, abort, winLen, resultReady,
    input  busy, resultValid, resultCount
  );
  modport slave (
    input  start, abort, winLen, resultReady,
    output busy, resultValid, resultCount
  );
`endif
endinterface

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer with rising-edge detector for the ring output.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic asyncIn,
  output logic risePulse
);

  logic sync_a;
  logic sync_b;
  logic hist;

  // On clr the history takes the value sync_b is about to hold, so a level
  // that is already high when the window opens never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= 1'b0;
    end else begin
      sync_a <= asyncIn;
      sync_b <= sync_a;
      hist   <= clr ? sync_a : sync_b;
    end
  end

  assign risePulse = sync_b & ~hist;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enable, settle, count edges over a window, hand off.
// Optional RO_MEAS_SAT_EN makes the counter saturate and reports it on resultOvf.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  ro_meas_ctrl_if.slave  host,
  input  logic           roOut,
  output logic           roEnable
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = max_int(WIN_W, SET_W);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

  meas_state_t      state;
  logic [TMR_W-1:0] timer;
  logic [WIN_W-1:0] win_lat;
  logic [WIN_W-1:0] win_last;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             result_valid;
  logic             settle_end;
  logic             rise;
`ifdef RO_MEAS_SAT_EN
  logic             ovf;
`endif

  assign settle_end = (state == SETTLE) && (timer == SETTLE_LAST);
  assign win_last   = win_lat - WIN_W'(1);

  ro_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clr       (settle_end),
    .asyncIn   (roOut),
    .risePulse (rise)
  );

  // Abort outranks everything, so it is handled ahead of the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      win_lat      <= '0;
      count        <= '0;
      roEnable     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
`ifdef RO_MEAS_SAT_EN
      ovf          <= 1'b0;
`endif
    end else if (host.abort) begin
      state        <= IDLE;
      roEnable     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            win_lat  <= (host.winLen == '0) ? WIN_W'(1) : host.winLen;
            timer    <= '0;
            count    <= '0;
`ifdef RO_MEAS_SAT_EN
            ovf      <= 1'b0;
`endif
            state    <= SETTLE;
            roEnable <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_end) begin
            state <= MEASURE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
`ifdef RO_MEAS_SAT_EN
            if (count == '1) ovf <= 1'b1;
            else             count <= count + CNT_W'(1);
`else
            count <= count + CNT_W'(1);
`endif
          end
          if (timer == TMR_W'(win_last)) begin
            state        <= DONE;
            roEnable     <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          if (host.resultReady) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy        = busy;
  assign host.resultValid = result_valid;
  assign host.resultCount = count;
`ifdef RO_MEAS_SAT_EN
  assign host.resultOvf   = ovf;
`endif

endmodule
